math_rp_arbiter: RTL and testbench

//  Shares one math_rp reconfigurable-partition operator (4b in1/in2, registered 8b out) among NUM_REQ requesters.

---
 rtl/math_rp_arbiter.sv | 139 +++++++++++++
 tb/tb_math_rp_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/math_rp_arbiter.sv
// Round-robin arbiter sharing one math_rp reconfigurable-partition operator among NUM_REQ requesters.
// Optional statistics counters (op_count, stall_count) are built only when MATH_ARB_STATS_EN is defined.
module math_rp_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MATH_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_in1,
  input  logic [4*NUM_REQ-1:0] req_in2,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [7:0]           rsp_data,
  output logic [3:0]           math_in1,
  output logic [3:0]           math_in2,
  input  logic [7:0]           math_out,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [15:0]          op_count,
  output logic [15:0]          stall_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_p0, state_nxt;
  logic [2:0] last_grant;
  logic [2:0] winner;
  logic       any_req;
  logic [3:0] sel_in1, sel_in2;
  logic [3:0] op1_p0, op2_p0;
  logic [2:0] wait_cnt;
  logic       gnt_rsp_ready;

  // First requester with req_valid set, searching upward from last+1 and wrapping.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] vld, input logic [2:0] last);
    logic [2:0] pick;
    int         idx;
    pick = 3'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (vld[idx]) pick = 3'(idx);
    end
    return pick;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign any_req = |req_valid;
  assign winner  = rr_pick(req_valid, last_grant);
  assign busy    = (state_p0 != IDLE);

  always_comb begin
    sel_in1       = 4'd0;
    sel_in2       = 4'd0;
    gnt_rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 3'(i)) begin
        sel_in1 = req_in1[4*i +: 4];
        sel_in2 = req_in2[4*i +: 4];
      end
      if (grant_id == 3'(i)) gnt_rsp_ready = rsp_ready[i];
    end
  end

  always_comb begin
    state_nxt = state_p0;
    req_ready = '0;
    rsp_valid = '0;
    math_in1  = 4'd0;
    math_in2  = 4'd0;
    case (state_p0)
      IDLE: begin
        for (int i = 0; i < NUM_REQ; i++) req_ready[i] = any_req && (winner == 3'(i));
        if (any_req) state_nxt = EXEC;
      end
      EXEC: begin
        math_in1 = op1_p0;
        math_in2 = op2_p0;
        if (wait_cnt == 3'(MATH_LAT)) state_nxt = RESP;
      end
      RESP: begin
        for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] = (grant_id == 3'(i));
        if (gnt_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture stage: operands at grant, RP result once its latency has elapsed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0   <= IDLE;
      last_grant <= 3'(NUM_REQ - 1);
      grant_id   <= 3'd0;
      wait_cnt   <= 3'd0;
      op1_p0     <= 4'd0;
      op2_p0     <= 4'd0;
      rsp_data   <= 8'd0;
    end else begin
      state_p0 <= state_nxt;
      case (state_p0)
        IDLE: begin
          if (any_req) begin
            op1_p0     <= sel_in1;
            op2_p0     <= sel_in2;
            grant_id   <= winner;
            last_grant <= winner;
            wait_cnt   <= 3'd0;
          end
        end
        EXEC: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_cnt == 3'(MATH_LAT)) rsp_data <= math_out;
        end
        default: ;
      endcase
    end
  end

`ifdef MATH_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count    <= 16'd0;
      stall_count <= 16'd0;
    end else if (state_p0 == RESP) begin
      if (gnt_rsp_ready) op_count    <= op_count + 16'd1;
      else               stall_count <= sat_inc16(stall_count);
    end
  end
`else
  assign op_count    = 16'd0;
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_math_rp_arbiter.sv
// Bench for math_rp_arbiter: a timeline model of the arbiter checked every cycle on two instances
// (4 requesters / latency 1, 8 requesters / latency 3) plus directed literal checks.
module tb_math_rp_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: NUM_REQ=4, MATH_LAT=1
  logic [3:0]  req_valid_a = '0, rsp_ready_a = 4'hF, req_ready_a, rsp_valid_a;
  logic [15:0] in1_a = '0, in2_a = '0;
  logic [7:0]  rsp_data_a, rp_out_a;
  logic [3:0]  m1_a, m2_a;
  logic        busy_a;
  logic [2:0]  gid_a;
  logic [15:0] opc_a, stc_a;

  // Instance B: NUM_REQ=8, MATH_LAT=3
  logic [7:0]  req_valid_b = '0, rsp_ready_b = 8'hFF, req_ready_b, rsp_valid_b;
  logic [31:0] in1_b = '0, in2_b = '0;
  logic [7:0]  rsp_data_b, rp_out_b, rp_b1, rp_b2;
  logic [3:0]  m1_b, m2_b;
  logic        busy_b;
  logic [2:0]  gid_b;
  logic [15:0] opc_b, stc_b;

  math_rp_arbiter #(.NUM_REQ(4), .MATH_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_in1(in1_a), .req_in2(in2_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_data(rsp_data_a), .math_in1(m1_a), .math_in2(m2_a), .math_out(rp_out_a),
    .busy(busy_a), .grant_id(gid_a), .op_count(opc_a), .stall_count(stc_a));

  math_rp_arbiter #(.NUM_REQ(8), .MATH_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_in1(in1_b), .req_in2(in2_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_data(rsp_data_b), .math_in1(m1_b), .math_in2(m2_b), .math_out(rp_out_b),
    .busy(busy_b), .grant_id(gid_b), .op_count(opc_b), .stall_count(stc_b));

  // RP models: out = 2*in1 + in2 after MATH_LAT register stages
  always @(posedge clk) begin
    rp_out_a <= 8'({4'd0, m1_a} * 2 + {4'd0, m2_a});
    rp_b1    <= 8'({4'd0, m1_b} * 2 + {4'd0, m2_b});
    rp_b2    <= rp_b1;
    rp_out_b <= rp_b2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: cycles since handshake determine EXEC vs RESP.
  bit         m_busy[2];
  int         m_last[2], m_cnt[2], m_id[2], m_gid[2], m_ops[2], m_stalls[2];
  logic [7:0] m_data[2];
  logic [3:0] m_in1[2], m_in2[2];

  task automatic model_reset(input int k, input int n);
    m_busy[k] = 1'b0; m_last[k] = n - 1; m_cnt[k] = 0; m_id[k] = 0; m_gid[k] = 0;
    m_ops[k] = 0; m_stalls[k] = 0; m_data[k] = 8'd0; m_in1[k] = 4'd0; m_in2[k] = 4'd0;
  endtask

  task automatic model_step(input int k, input int n, input int lat, input logic rst_now,
                            input logic [7:0] rv, input logic [7:0] rrdy,
                            input logic [31:0] i1, input logic [31:0] i2,
                            input logic [7:0] d_rr, input logic [7:0] d_rv, input logic [7:0] d_data,
                            input logic [3:0] d_m1, input logic [3:0] d_m2, input logic d_busy,
                            input logic [2:0] d_gid, input logic [15:0] d_ops, input logic [15:0] d_st);
    logic [7:0] e_rr, e_rv;
    logic [3:0] e_m1, e_m2;
    int w, idx;
    string p;
    p = (k == 0) ? "A" : "B";
    e_rr = '0; e_rv = '0; e_m1 = '0; e_m2 = '0; w = -1;
    if (rst_now) model_reset(k, n);
    else if (!m_busy[k]) begin
      for (int j = n; j >= 1; j--) begin
        idx = (m_last[k] + j) % n;
        if (rv[idx]) w = idx;
      end
      if (w >= 0) e_rr = 8'(1 << w);
    end else if (m_cnt[k] <= lat + 1) begin
      e_m1 = m_in1[k]; e_m2 = m_in2[k];
    end else e_rv = 8'(1 << m_id[k]);

    chk({p, "_req_ready"}, {24'd0, d_rr}, {24'd0, e_rr});
    chk({p, "_rsp_valid"}, {24'd0, d_rv}, {24'd0, e_rv});
    chk({p, "_math_in"}, {24'd0, d_m1, d_m2}, {24'd0, e_m1, e_m2});
    chk({p, "_busy"}, {31'd0, d_busy}, {31'd0, m_busy[k]});
    chk({p, "_grant_id"}, {29'd0, d_gid}, m_gid[k]);
    if (rst_now) chk({p, "_rsp_data_rst"}, {24'd0, d_data}, 0);
    else if (e_rv != 0) chk({p, "_rsp_data"}, {24'd0, d_data}, {24'd0, m_data[k]});
`ifdef MATH_ARB_STATS_EN
    chk({p, "_op_count"}, {16'd0, d_ops}, m_ops[k]);
    chk({p, "_stall_count"}, {16'd0, d_st}, m_stalls[k]);
`else
    chk({p, "_op_count"}, {16'd0, d_ops}, 0);
    chk({p, "_stall_count"}, {16'd0, d_st}, 0);
`endif

    if (rst_now) ;
    else if (!m_busy[k]) begin
      if (w >= 0) begin
        m_busy[k] = 1'b1; m_cnt[k] = 1; m_id[k] = w; m_last[k] = w; m_gid[k] = w;
        m_in1[k] = i1[4*w +: 4]; m_in2[k] = i2[4*w +: 4];
        m_data[k] = 8'(int'(m_in1[k]) * 2 + int'(m_in2[k]));
      end
    end else if (e_rv != 0) begin
      if (rrdy[m_id[k]]) begin
        m_ops[k] = (m_ops[k] + 1) & 16'hFFFF;
        m_busy[k] = 1'b0;
      end else if (m_stalls[k] < 16'hFFFF) m_stalls[k]++;
    end else m_cnt[k]++;
  endtask

  initial begin
    model_reset(0, 4);
    model_reset(1, 8);
  end

  always @(negedge clk) begin
    model_step(0, 4, 1, reset, {4'd0, req_valid_a}, {4'd0, rsp_ready_a}, {16'd0, in1_a}, {16'd0, in2_a},
               {4'd0, req_ready_a}, {4'd0, rsp_valid_a}, rsp_data_a, m1_a, m2_a, busy_a, gid_a, opc_a, stc_a);
    model_step(1, 8, 3, reset, req_valid_b, rsp_ready_b, in1_b, in2_b,
               req_ready_b, rsp_valid_b, rsp_data_b, m1_b, m2_b, busy_b, gid_b, opc_b, stc_b);
  end

  function automatic logic [7:0] cur_rr(input int k);
    return (k != 0) ? req_ready_b : {4'd0, req_ready_a};
  endfunction
  function automatic logic [7:0] cur_rqv(input int k);
    return (k != 0) ? req_valid_b : {4'd0, req_valid_a};
  endfunction
  function automatic logic [7:0] cur_rv(input int k);
    return (k != 0) ? rsp_valid_b : {4'd0, rsp_valid_a};
  endfunction

  task automatic wait_hs(input int k, output int gid, output int t);
    logic [7:0] hs;
    bit found;
    found = 0; gid = -1; t = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      hs = cur_rr(k) & cur_rqv(k);
      if (hs != 0) begin
        found = 1; t = cyc;
        for (int j = 0; j < 8; j++) if (hs[j]) gid = j;
      end
    end
    if (!found) chk("handshake_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int k, output logic [7:0] d, output int t);
    bit found;
    found = 0; d = 8'd0; t = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (cur_rv(k) != 0) begin
        found = 1; t = cyc;
        d = (k != 0) ? rsp_data_b : rsp_data_a;
      end
    end
    if (!found) chk("response_timeout", 0, 1);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    drive_edge();
    reset = 1'b1;
    drive_edge();
    reset = 1'b0;
  endtask

  initial begin
    int g, th, tr, tprev;
    logic [7:0] d;
    int exp_g[5];
    int exp_d[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{3, 6, 9, 12, 3};

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // T1: single request, 3+4*... -> 2*3+4 = 0x0A
    req_valid_a = 4'b0001; in1_a = 16'h0003; in2_a = 16'h0004;
    @(negedge clk);
    chk("T1_req_ready_same_cycle", {28'd0, req_ready_a}, 32'h1);
    th = cyc;
    drive_edge();
    req_valid_a = '0;
    wait_rsp(0, d, tr);
    chk("T1_latency", tr - th, 3);
    chk("T1_rsp_valid", {28'd0, rsp_valid_a}, 32'h1);
    chk("T1_rsp_data", {24'd0, d}, 32'h0A);
    @(posedge clk); @(negedge clk);
`ifdef MATH_ARB_STATS_EN
    chk("T1_op_count", {16'd0, opc_a}, 1);
`else
    chk("T1_op_count", {16'd0, opc_a}, 0);
`endif

    // T2: all four requesting, grants rotate from 0
    reset_pulse();
    req_valid_a = 4'hF; in1_a = 16'h4321; in2_a = 16'h4321;
    tprev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_hs(0, g, th);
      chk($sformatf("T2_grant%0d", i), g, exp_g[i]);
      if (i > 0) chk($sformatf("T2_interval%0d", i), th - tprev, 4);
      tprev = th;
      wait_rsp(0, d, tr);
      chk($sformatf("T2_data%0d", i), {24'd0, d}, exp_d[i]);
    end

    // T3: full-scale operands and a 5-cycle response stall
    drive_edge();
    req_valid_a = 4'b0001; in1_a = 16'h000F; in2_a = 16'h000F; rsp_ready_a = 4'h0;
    wait_hs(0, g, th);
    chk("T3_grant", g, 0);
    drive_edge();
    req_valid_a = '0;
    wait_rsp(0, d, tr);
    chk("T3_rsp_data", {24'd0, d}, 32'h2D);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("T3_hold_valid", {28'd0, rsp_valid_a}, 32'h1);
      chk("T3_hold_data", {24'd0, rsp_data_a}, 32'h2D);
      chk("T3_busy", {31'd0, busy_a}, 1);
    end
    drive_edge();
    rsp_ready_a = 4'hF;
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("T3_idle_after", {31'd0, busy_a}, 0);
`ifdef MATH_ARB_STATS_EN
    chk("T3_stall_count", {16'd0, stc_a}, 5);
    chk("T3_op_count", {16'd0, opc_a}, 6);
`else
    chk("T3_stall_count", {16'd0, stc_a}, 0);
    chk("T3_op_count", {16'd0, opc_a}, 0);
`endif

    // T4: reset during EXEC aborts, priority restarts at requester 0
    drive_edge();
    req_valid_a = 4'b0001; in1_a = 16'h0065; in2_a = 16'h0071;
    wait_hs(0, g, th);
    drive_edge();
    req_valid_a = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("T4_no_rsp_in_reset", {28'd0, rsp_valid_a}, 0);
    drive_edge();
    reset = 1'b0;
    req_valid_a = 4'b0110;
    wait_hs(0, g, th);
    chk("T4_first_grant", g, 1);
    drive_edge();
    req_valid_a = '0;
    wait_rsp(0, d, tr);
    chk("T4_latency", tr - th, 3);
    chk("T4_rsp_data", {24'd0, d}, 32'h13);

    // T5: 8 requesters, latency 3, only requester 7, back-to-back
    drive_edge();
    req_valid_b = 8'h80; in1_b = 32'h9000_0000; in2_b = 32'h2000_0000;
    tprev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_hs(1, g, th);
      chk("T5_grant", g, 7);
      if (i > 0) chk("T5_interval", th - tprev, 6);
      tprev = th;
      wait_rsp(1, d, tr);
      chk("T5_latency", tr - th, 5);
      chk("T5_rsp_data", {24'd0, d}, 32'h14);
      chk("T5_grant_id", {29'd0, gid_b}, 7);
    end
    drive_edge();
    req_valid_b = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1);
  end

endmodule
